// File: rtl/vga_pkg.sv
// Shared timing constants, frame-buffer geometry and register map for vga_bus.
// Optional 0xB5 pattern register decode is gated by VGABUS_TEST_PATTERN_EN.
package vga_pkg;

    localparam int unsigned CNT_W         = 10;

    localparam int unsigned H_VISIBLE     = 640;
    localparam int unsigned H_FRONT       = 16;
    localparam int unsigned H_SYNC        = 96;
    localparam int unsigned H_TOTAL       = 800;
    localparam int unsigned H_SYNC_START  = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END    = H_SYNC_START + H_SYNC;

    localparam int unsigned V_VISIBLE     = 480;
    localparam int unsigned V_FRONT       = 10;
    localparam int unsigned V_SYNC        = 2;
    localparam int unsigned V_TOTAL       = 525;
    localparam int unsigned V_SYNC_START  = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END    = V_SYNC_START + V_SYNC;

    localparam int unsigned FB_WIDTH      = 160;
    localparam int unsigned FB_HEIGHT     = 120;
    localparam int unsigned FB_XW         = 8;
    localparam int unsigned FB_YW         = 7;
    localparam int unsigned FB_AW         = FB_XW + FB_YW;
    localparam int unsigned FB_DEPTH      = 1 << FB_AW;

    localparam int unsigned BUS_W         = 8;
    localparam int unsigned COLOUR_W      = 8;

    localparam logic [BUS_W-1:0] REG_X    = 8'hB0;
    localparam logic [BUS_W-1:0] REG_Y    = 8'hB1;
    localparam logic [BUS_W-1:0] REG_PIX  = 8'hB2;
    localparam logic [BUS_W-1:0] REG_FG   = 8'hB3;
    localparam logic [BUS_W-1:0] REG_BG   = 8'hB4;
    localparam logic [BUS_W-1:0] REG_PAT  = 8'hB5;

    localparam logic [COLOUR_W-1:0] FG_RESET = 8'hFF;
    localparam logic [COLOUR_W-1:0] BG_RESET = 8'h00;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_X,
        SEL_Y,
        SEL_PIX,
        SEL_FG,
        SEL_BG,
        SEL_PAT
    } reg_sel_e;

    // Address decode; 0xB5 only exists when the pattern feature is built in.
    function automatic reg_sel_e decode_addr(input logic [BUS_W-1:0] addr);
        reg_sel_e sel;
        sel = SEL_NONE;
        case (addr)
            REG_X:   sel = SEL_X;
            REG_Y:   sel = SEL_Y;
            REG_PIX: sel = SEL_PIX;
            REG_FG:  sel = SEL_FG;
            REG_BG:  sel = SEL_BG;
`ifdef VGABUS_TEST_PATTERN_EN
            REG_PAT: sel = SEL_PAT;
`endif
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/vga_bus_if.sv
// Write-only CPU bus seen by the VGA peripheral (address, data, write strobe).
interface vga_bus_if;

    logic [7:0] ADDR;
    logic [7:0] DATA;
    logic       BUS_WE;

    modport master (output ADDR, output DATA, output BUS_WE);
    modport slave  (input  ADDR, input  DATA, input  BUS_WE);

endinterface

// File: rtl/vga_frame_buffer.sv
// 32768x1 simple dual-port RAM: synchronous write port A, registered read port B.
// Contents are never reset; a same-address write and read return the old bit.
module vga_frame_buffer
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_a_we,
    input  logic [FB_AW-1:0] i_a_addr,
    input  logic             i_a_data,
    input  logic [FB_AW-1:0] i_b_addr,
    output logic             o_b_data
);

    logic r_mem [0:FB_DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_data;
        end
    end

    // Only the output register is reset; the storage array powers up unknown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_b_data <= 1'b0;
        end else begin
            o_b_data <= r_mem[i_b_addr];
        end
    end

endmodule

// File: rtl/vga_bus.sv
// Bus-mapped 160x120 one-bit frame buffer scanned out as 640x480@60 VGA (4x4 blocks).
// Define VGABUS_TEST_PATTERN_EN to add register 0xB5 selecting a counter-derived test pattern.
module vga_bus
    import vga_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    vga_bus_if.slave            bus,
    output logic                VGA_HS,
    output logic                VGA_VS,
    output logic [COLOUR_W-1:0] VGA_COLOUR
);

    logic [1:0]          r_pix_div;
    logic                w_pix_en;
    logic [CNT_W-1:0]    r_h;
    logic [CNT_W-1:0]    r_v;

    logic [FB_XW-1:0]    r_x;
    logic [FB_YW-1:0]    r_y;
    logic [COLOUR_W-1:0] r_fg;
    logic [COLOUR_W-1:0] r_bg;

    reg_sel_e            w_sel;
    logic                w_fb_we;
    logic [FB_AW-1:0]    w_fb_wr_addr;
    logic [FB_AW-1:0]    w_fb_rd_addr;
    logic                w_fb_bit;

    logic                w_hs_n;
    logic                w_vs_n;
    logic                w_visible;
    logic                r_blank_d;

`ifdef VGABUS_TEST_PATTERN_EN
    logic                r_pat_en;
    logic [COLOUR_W-1:0] r_pat_col;
`endif

    // Free-running divide-by-4 pixel enable.
    assign w_pix_en = (r_pix_div == 2'd3);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_pix_div <= 2'd0;
        end else begin
            r_pix_div <= r_pix_div + 2'd1;
        end
    end

    // H/V scan counters; V steps on the same enable that wraps H.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_pix_en) begin
            if (r_h == CNT_W'(H_TOTAL - 1)) begin
                r_h <= '0;
                if (r_v == CNT_W'(V_TOTAL - 1)) begin
                    r_v <= '0;
                end else begin
                    r_v <= r_v + CNT_W'(1);
                end
            end else begin
                r_h <= r_h + CNT_W'(1);
            end
        end
    end

    assign w_sel = bus.BUS_WE ? decode_addr(bus.ADDR) : SEL_NONE;

    // Pixel writes use X/Y as held before this edge and are dropped off-grid.
    assign w_fb_we      = (w_sel == SEL_PIX)
                          && (r_x < FB_XW'(FB_WIDTH))
                          && (r_y < FB_YW'(FB_HEIGHT));
    assign w_fb_wr_addr = {r_y, r_x};
    assign w_fb_rd_addr = {r_v[8:2], r_h[9:2]};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_x  <= '0;
            r_y  <= '0;
            r_fg <= FG_RESET;
            r_bg <= BG_RESET;
        end else begin
            case (w_sel)
                SEL_X:   r_x  <= bus.DATA;
                SEL_Y:   r_y  <= bus.DATA[FB_YW-1:0];
                SEL_FG:  r_fg <= bus.DATA;
                SEL_BG:  r_bg <= bus.DATA;
                default: ;
            endcase
        end
    end

`ifdef VGABUS_TEST_PATTERN_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_pat_en <= 1'b0;
        end else if (w_sel == SEL_PAT) begin
            r_pat_en <= bus.DATA[0];
        end
    end

    // Pattern colour is captured alongside the RAM read so both line up.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_pat_col <= '0;
        end else begin
            r_pat_col <= {r_h[7:5], r_v[7:5], r_h[4:3]};
        end
    end
`endif

    vga_frame_buffer u_fb (
        .clk      (CLK),
        .rst_n    (RESET),
        .i_a_we   (w_fb_we),
        .i_a_addr (w_fb_wr_addr),
        .i_a_data (bus.DATA[0]),
        .i_b_addr (w_fb_rd_addr),
        .o_b_data (w_fb_bit)
    );

    assign w_hs_n    = !in_window(r_h, CNT_W'(H_SYNC_START), CNT_W'(H_SYNC_END));
    assign w_vs_n    = !in_window(r_v, CNT_W'(V_SYNC_START), CNT_W'(V_SYNC_END));
    assign w_visible = (r_h < CNT_W'(H_VISIBLE)) && (r_v < CNT_W'(V_VISIBLE));

    // Syncs and blanking take one register stage, matching the RAM read latency.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            r_blank_d <= 1'b1;
        end else begin
            VGA_HS    <= w_hs_n;
            VGA_VS    <= w_vs_n;
            r_blank_d <= !w_visible;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            VGA_COLOUR <= '0;
        end else begin
            if (r_blank_d) begin
                VGA_COLOUR <= '0;
            end
`ifdef VGABUS_TEST_PATTERN_EN
            else if (r_pat_en) begin
                VGA_COLOUR <= r_pat_col;
            end
`endif
            else begin
                VGA_COLOUR <= w_fb_bit ? r_fg : r_bg;
            end
        end
    end

endmodule

// File: tb/tb_vga_bus.sv
// Scoreboard bench for vga_bus: a cycle model pushes expected sync/colour per clock,
// a negedge monitor pops and compares; sync timing after a mid-frame reset is measured directly.
module tb_vga_bus;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       VGA_HS;
    logic       VGA_VS;
    logic [7:0] VGA_COLOUR;

    always #5 CLK = ~CLK;

    vga_bus_if bus ();

    vga_bus dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .bus        (bus),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_COLOUR (VGA_COLOUR)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        hs;
        logic        vs;
        logic        chk_col;
        logic [7:0]  col;
        int unsigned c;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned c_cnt  = 0;
    bit          run_sb = 0;

    // Bench-side shadow of the register file and of FB rows 0..3.
    logic        fb_m [0:3][0:159];
    logic [7:0]  sx = 8'd0;
    logic [6:0]  sy = 7'd0;
    logic [7:0]  sfg = 8'hFF;
    logic [7:0]  sbg = 8'h00;
    logic [7:0]  fg1 = 8'h00, bg1 = 8'h00, fg2 = 8'h00, bg2 = 8'h00;
    int unsigned exp_we = 0;
    int unsigned we_cnt = 0;

    // Expected outputs right after clock edge c following reset release.
    function automatic exp_t model(input int unsigned c);
        exp_t        e;
        int unsigned p, h, v;
        logic [7:0]  fg, bg;
        p = (c - 1) / 4;
        h = p % 800;
        v = (p / 800) % 525;
        e.hs      = !(h >= 656 && h < 752);
        e.vs      = !(v >= 490 && v < 492);
        e.chk_col = 1'b0;
        e.col     = 8'h00;
        e.c       = c;
        fg        = 8'h00;
        bg        = 8'h00;
        if (c >= 2) begin
            p = (c - 2) / 4;
            h = p % 800;
            v = (p / 800) % 525;
            if (v >= 1 && v <= 7) begin
                e.chk_col = 1'b1; fg = fg1; bg = bg1;
            end else if (v >= 9 && v <= 15) begin
                e.chk_col = 1'b1; fg = fg2; bg = bg2;
            end else if (v >= 17 && v <= 19) begin
                e.chk_col = 1'b1; fg = 8'hFF; bg = 8'hFF;
            end
            if (e.chk_col) begin
                if (h < 640 && v < 480)
                    e.col = (v < 16 && fb_m[2'(v >> 2)][8'(h >> 2)] == 1'b1) ? fg : bg;
                else
                    e.col = 8'h00;
            end
        end
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge CLK);
            if (run_sb) begin
                c_cnt++;
                sb_q.push_back(model(c_cnt));
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("hs@%0d", e.c), 32'(VGA_HS), 32'(e.hs));
                check($sformatf("vs@%0d", e.c), 32'(VGA_VS), 32'(e.vs));
                if (e.chk_col)
                    check($sformatf("colour@%0d", e.c), 32'(VGA_COLOUR), 32'(e.col));
            end
        end
    end

    // Count frame-buffer write strobes just before each sampling edge.
    initial begin
        forever begin
            @(negedge CLK);
            #4;
            if (dut.w_fb_we === 1'b1) we_cnt++;
        end
    end

    task automatic idle();
        bus.ADDR   = 8'h00;
        bus.DATA   = 8'h00;
        bus.BUS_WE = 1'b0;
    endtask

    // Present one write for the next edge and update the shadow model.
    task automatic drive(input logic [7:0] a, input logic [7:0] d);
        bus.ADDR   = a;
        bus.DATA   = d;
        bus.BUS_WE = 1'b1;
        case (a)
            8'hB0: sx = d;
            8'hB1: sy = d[6:0];
            8'hB2: if (sx < 8'd160 && sy < 7'd120) begin
                       exp_we++;
                       if (sy < 7'd4) fb_m[sy[1:0]][sx] = d[0];
                   end
            8'hB3: sfg = d;
            8'hB4: sbg = d;
            default: ;
        endcase
        @(negedge CLK);
    endtask

    task automatic wait_cycle(input int unsigned target);
        while (c_cnt < target) @(negedge CLK);
    endtask

    initial begin
        int unsigned n, w, q;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 160; x++)
                fb_m[y][x] = 1'b0;
        idle();
        RESET = 1'b1;
        #2 RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_hs", 32'(VGA_HS), 32'd1);
        check("reset_vs", 32'(VGA_VS), 32'd1);
        check("reset_colour", 32'(VGA_COLOUR), 32'h00);

        RESET  = 1'b1;
        c_cnt  = 0;
        run_sb = 1;

        // Line 0: clear FB rows 0..3, off-grid writes, then the address/data sweep.
        for (int y = 0; y < 4; y++) begin
            drive(8'hB1, 8'(y));
            for (int x = 0; x < 160; x++) begin
                drive(8'hB0, 8'(x));
                drive(8'hB2, 8'h00);
            end
        end
        drive(8'hB0, 8'd160);
        drive(8'hB1, 8'd0);
        drive(8'hB2, 8'h01);
        drive(8'hB1, 8'hFF);
        drive(8'hB0, 8'd10);
        drive(8'hB2, 8'h01);
        for (int i = 0; i < 450; i++)
            drive(8'(32'hB0 + i / 90), 8'(32'h78 + i / 20));
        idle();
        @(negedge CLK);
        fg1 = sfg;
        bg1 = sbg;
        check("fb_we_after_sweep", we_cnt, exp_we);
        check("sweep_done_in_line0", 32'(c_cnt < 3200), 32'd1);

        // Line 8: single pixel plus colours, visible on lines 12..15.
        wait_cycle(8 * 3200 + 8);
        drive(8'hB0, 8'd5);
        drive(8'hB1, 8'd3);
        drive(8'hB2, 8'h01);
        drive(8'hB3, 8'hE0);
        drive(8'hB4, 8'h03);
        idle();
        @(negedge CLK);
        fg2 = sfg;
        bg2 = sbg;
        check("fb_we_after_pixel", we_cnt, exp_we);

        // Line 16: FG=BG so only blanking can produce 0x00.
        wait_cycle(16 * 3200 + 8);
        drive(8'hB3, 8'hFF);
        drive(8'hB4, 8'hFF);
        idle();

        // Mid-line reset while HS is low.
        wait_cycle(19 * 3200 + 2800);
        run_sb = 0;
        @(negedge CLK);
        @(negedge CLK);
        check("hs_low_before_reset", 32'(VGA_HS), 32'd0);
        #1 RESET = 1'b0;
        #1;
        check("async_reset_hs", 32'(VGA_HS), 32'd1);
        check("async_reset_vs", 32'(VGA_VS), 32'd1);
        check("async_reset_colour", 32'(VGA_COLOUR), 32'h00);
        repeat (4) @(negedge CLK);
        RESET = 1'b1;

        n = 0;
        while (VGA_HS !== 1'b0 && n < 4000) begin
            @(posedge CLK); #1; n++;
        end
        check("first_hs_low_clk", n, 32'd2625);
        w = 0;
        while (VGA_HS === 1'b0 && w < 1000) begin
            @(posedge CLK); #1; w++;
        end
        check("hs_width_clk", w, 32'd384);
        q = w;
        while (VGA_HS !== 1'b0 && q < 4000) begin
            @(posedge CLK); #1; q++;
        end
        check("hs_period_clk", q, 32'd3200);
        check("vs_idle_after_reset", 32'(VGA_VS), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
